// File: rtl/uart_rx.sv
// UART receiver: 8N1, oversampled, mid-bit sampling.
// Ports: clk, rst (async, active-high), rx (async serial in),
//        rx_data (last byte), rx_done (1-clk end-of-frame pulse),
//        frame_err (stop-bit status, held), rx_busy (not idle).
module uart_rx #(
    parameter int SYS_CLK    = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int TICK_COUNT = SYS_CLK / (BAUD * OVERSAMPLE);
    localparam int CW = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
    localparam logic [CW-1:0] TICK_MAX = CW'(TICK_COUNT - 1);
    localparam logic [3:0] S_MID  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] S_LAST = 4'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t state, state_n;

    logic          rx_m, rx_s, rx_prev;
    logic [CW-1:0] div_cnt;
    logic          tick;
    logic [3:0]    s_cnt, s_cnt_n;
    logic [2:0]    b_cnt, b_cnt_n;
    logic [7:0]    shreg, shreg_n;
    logic [7:0]    rx_data_n;
    logic          rx_done_n;
    logic          frame_err_n;

    // Synchronizer and edge history idle high so reset looks like a quiet line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_m    <= rx;
            rx_s    <= rx_m;
            rx_prev <= rx_s;
        end
    end

    // Free-running divider: the tick phase is not aligned to the start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (div_cnt == TICK_MAX) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = (div_cnt == TICK_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            s_cnt     <= '0;
            b_cnt     <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            s_cnt     <= s_cnt_n;
            b_cnt     <= b_cnt_n;
            shreg     <= shreg_n;
            rx_data   <= rx_data_n;
            rx_done   <= rx_done_n;
            frame_err <= frame_err_n;
        end
    end

    always_comb begin
        state_n     = state;
        s_cnt_n     = s_cnt;
        b_cnt_n     = b_cnt;
        shreg_n     = shreg;
        rx_data_n   = rx_data;
        rx_done_n   = 1'b0;
        frame_err_n = frame_err;
        unique case (state)
            IDLE: begin
                // Edge, not level: a line stuck low never restarts a frame.
                if (rx_prev && !rx_s) begin
                    s_cnt_n = '0;
                    state_n = START;
                end
            end
            START: begin
                if (tick) begin
                    if (s_cnt == S_MID) begin
                        if (!rx_s) begin
                            s_cnt_n = '0;
                            b_cnt_n = '0;
                            state_n = DATA;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        s_cnt_n = s_cnt + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_cnt == S_LAST) begin
                        s_cnt_n = '0;
                        shreg_n = {rx_s, shreg[7:1]};
                        if (b_cnt == 3'd7) begin
                            state_n = STOP;
                        end else begin
                            b_cnt_n = b_cnt + 3'd1;
                        end
                    end else begin
                        s_cnt_n = s_cnt + 4'd1;
                    end
                end
            end
            STOP: begin
                // Leave at mid-stop so a back-to-back start edge is seen.
                if (tick) begin
                    if (s_cnt == S_LAST) begin
                        rx_data_n   = shreg;
                        rx_done_n   = 1'b1;
                        frame_err_n = ~rx_s;
                        state_n     = IDLE;
                    end else begin
                        s_cnt_n = s_cnt + 4'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx, scaled to 8 clk per tick.
// Directed frames push expectations; a monitor checks each rx_done.
module tb_uart_rx;

    localparam int SYS_CLK = 1_228_800;
    localparam int BAUD    = 9600;
    localparam int OVS     = 16;
    localparam int BIT     = 128;
    localparam int BIT_F   = 125;
    localparam int BIT_S   = 131;

    typedef struct packed {
        logic [7:0] d;
        logic       e;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       rx_busy;

    exp_t q[$];
    int   passed;
    int   total;

    uart_rx #(
        .SYS_CLK(SYS_CLK),
        .BAUD(BAUD),
        .OVERSAMPLE(OVS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .rx_data(rx_data),
        .rx_done(rx_done),
        .frame_err(frame_err),
        .rx_busy(rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rx_done) begin
            if (q.size() == 0) begin
                check("unexpected_rx_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("rx_data", {24'd0, rx_data}, {24'd0, e.d});
                check("frame_err", {31'd0, frame_err}, {31'd0, e.e});
            end
        end
    end

    task automatic send_bit(input logic b, input int per);
        rx = b;
        repeat (per) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input int per, input bit expect_it);
        exp_t e;
        if (expect_it) begin
            e.d = d;
            e.e = ~stop;
            q.push_back(e);
        end
        send_bit(1'b0, per);
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i], per);
        end
        send_bit(stop, per);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 4000) begin
            @(posedge clk);
            n++;
        end
        check(name, q.size(), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        passed = 0;
        total  = 0;
        rst    = 1'b1;
        rx     = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_rx_done", {31'd0, rx_done}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_rx_busy", {31'd0, rx_busy}, 32'd0);
        rst = 1'b0;
        repeat (BIT) @(posedge clk);

        send_frame(8'h55, 1'b1, BIT, 1'b1);
        drain("drain_55");
        repeat (BIT) @(posedge clk);

        send_frame(8'hA3, 1'b1, BIT, 1'b1);
        send_frame(8'h0F, 1'b1, BIT, 1'b1);
        drain("drain_a3_0f");
        repeat (BIT) @(posedge clk);

        send_frame(8'hFF, 1'b0, BIT, 1'b1);
        repeat (3 * BIT) @(posedge clk);
        rx = 1'b1;
        drain("drain_ff_err");
        repeat (2 * BIT) @(posedge clk);

        rx = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("glitch_busy_hi", {31'd0, rx_busy}, 32'd1);
        repeat (32) @(posedge clk);
        rx = 1'b1;
        repeat (BIT) @(posedge clk);
        #1;
        check("glitch_busy_lo", {31'd0, rx_busy}, 32'd0);
        check("glitch_data", {24'd0, rx_data}, 32'hFF);
        check("glitch_ferr", {31'd0, frame_err}, 32'd1);

        send_bit(1'b0, BIT);
        for (int i = 0; i < 4; i++) begin
            send_bit(1'(8'h3C >> i), BIT);
        end
        send_bit(1'b1, BIT / 2);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (10) @(posedge clk);
        rst = 1'b0;
        repeat (2 * BIT) @(posedge clk);
        #1;
        check("abort_busy", {31'd0, rx_busy}, 32'd0);
        check("abort_data", {24'd0, rx_data}, 32'd0);
        check("abort_ferr", {31'd0, frame_err}, 32'd0);

        send_frame(8'hC3, 1'b1, BIT, 1'b1);
        drain("drain_c3");
        repeat (BIT) @(posedge clk);

        send_frame(8'h5A, 1'b1, BIT_F, 1'b1);
        drain("drain_5a_fast");
        repeat (BIT) @(posedge clk);
        send_frame(8'h5A, 1'b1, BIT_S, 1'b1);
        drain("drain_5a_slow");
        repeat (2 * BIT) @(posedge clk);
        #1;
        check("final_busy", {31'd0, rx_busy}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter SYS_CLK, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, line bit rate.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit period.
REQ-004 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port rx  input  1  serial line, asynchronous to clk, idle high.
REQ-007 SHALL have port rx_data  output  8  last received byte.
REQ-008 SHALL have port rx_done  output  1  one-clk pulse marking the end of each frame.
REQ-009 SHALL have port frame_err  output  1  stop-bit status of the last frame; valid with rx_done and held until the next rx_done.
REQ-010 SHALL have port rx_busy  output  1  high in every state except IDLE.

Function
REQ-011 SHALL pass rx through a 2-FF synchronizer; all logic SHALL use only the synchronized value rx_s; the synchronizer FFs SHALL reset to 1.
REQ-012 SHALL contain a free-running tick divider with TICK_COUNT = SYS_CLK/(BAUD*OVERSAMPLE), integer division, default 651; the counter SHALL count 0..TICK_COUNT-1 and wrap to 0.
REQ-013 SHALL assert the internal tick for exactly one clk, in the cycle the divider counter equals TICK_COUNT-1; the divider counter width SHALL be $clog2(TICK_COUNT).
REQ-014 SHALL implement the FSM states IDLE, START, DATA and STOP, with a sample counter s_cnt (4 bits, 0..15) and a bit counter b_cnt (3 bits).
REQ-015 IDLE: SHALL detect a falling edge (previous rx_s = 1, current rx_s = 0), then clear s_cnt and go to START; a line held low SHALL NOT retrigger.
REQ-016 START: SHALL increment s_cnt on each tick; on the tick where s_cnt == 7, if rx_s == 0 SHALL clear s_cnt and b_cnt and go to DATA, else (glitch) SHALL go to IDLE with no output change.
REQ-017 DATA: SHALL increment s_cnt on each tick; on the tick where s_cnt == 15, SHALL shift rx_s into the MSB of the shift register (shift right, LSB first on the line) and clear s_cnt; SHALL go to STOP after the 8th bit (b_cnt == 7), else increment b_cnt.
REQ-018 STOP: on the tick where s_cnt == 15, SHALL load rx_data from the shift register, pulse rx_done for 1 clk, set frame_err = ~rx_s, and go to IDLE in the same cycle.
REQ-019 SHALL update rx_data and pulse rx_done even on a framing error.
REQ-020 SHALL accept back-to-back frames: the return to IDLE at mid-stop SHALL allow the next start edge to be detected.
REQ-021 SHALL ignore rx_s activity outside of the sample points.
REQ-022 The latency from the start-bit mid-point to rx_done SHALL be 9*OVERSAMPLE ticks (+/- 1 tick jitter from the free-running divider).

Reset
REQ-023 On rst SHALL force: state IDLE, all counters 0, shift register 0, rx_data = 8'h00, rx_done = 0, frame_err = 0, rx_busy = 0, synchronizer and edge-history FFs = 1.
REQ-024 Reset asserted mid-frame SHALL abort the frame without producing rx_done; after release the block SHALL wait for a new falling edge.

Verification
REQ-025 Drive the frame 0x55 at 9600 baud (10417 clk/bit), stop = 1 -> exactly one rx_done, rx_data = 8'h55, frame_err = 0.
REQ-026 Drive 0xA3 then 0x0F back-to-back with no idle gap -> two rx_done pulses, with rx_data 8'hA3 then 8'h0F and frame_err = 0 for both.
REQ-027 Drive 0xFF with stop bit = 0, then hold rx low 3 bit times, then high -> one rx_done, rx_data = 8'hFF, frame_err = 1, and no second frame while rx is held low.
REQ-028 Drive a 3000-clk low glitch on an idle line -> no rx_done, rx_busy returns to 0, rx_data is unchanged.
REQ-029 Assert rst during bit 4 of 0x3C, release, then send 0xC3 -> no rx_done for the aborted frame, then rx_data = 8'hC3 and frame_err = 0.
REQ-030 Send 0x5A at a baud rate 2% fast and 2% slow -> rx_data = 8'h5A in both cases.
